updown_mod_counter: RTL and testbench

- Parametrised successor to the team's 4-bit up/down counter. One modulo counter with a direction flag toggled by Swap pulses.
- Mirrored outputs: UpCountS (count value) and DownCountS (complement to the limit).
- Adds configurable width, limit and step, synchronous load, wrap/saturate mode and limit/wrap status.
- Used as the generic counting primitive in timer and sequencer blocks.

---
 rtl/updown_mod_counter.sv | 111 +++++++++++
 tb/tb_updown_mod_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with swap-toggled direction, load, wrap/saturate and limit status.
// Optional reflect-at-limits mode enabled by defining UPDOWN_PINGPONG_EN (wrap mode only).
module updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Swap,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] UpCountS,
    output logic [WIDTH-1:0] DownCountS,
    output logic             Dir,
    output logic             AtLimit,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MaxW  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MaxE  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   ModE  = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH:0]   StepE = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             swap_q;
    logic             wrap_q, wrap_d;

    logic             swap_edge;
    logic [WIDTH:0]   cnt_e;
    logic [WIDTH:0]   up_sum;
    logic             up_ovf;
    logic             dn_ovf;

    always_comb begin
        swap_edge = Swap & ~swap_q;
        cnt_e     = {1'b0, cnt_q};
        up_sum    = cnt_e + StepE;
        up_ovf    = up_sum > MaxE;
        dn_ovf    = cnt_e < StepE;

        cnt_d  = cnt_q;
        dir_d  = dir_q ^ swap_edge;
        wrap_d = 1'b0;

        if (Load) begin
            cnt_d = ({1'b0, LoadVal} > MaxE) ? MaxW : LoadVal;
        end else if (Enable) begin
            if (!dir_q) begin
                if (!up_ovf) begin
                    cnt_d = WIDTH'(up_sum);
                end else if (SATURATE != 0) begin
                    // Clamping while already parked at the limit is not a new event.
                    cnt_d  = MaxW;
                    wrap_d = (cnt_q != MaxW);
                end else begin
                    cnt_d  = WIDTH'(up_sum - ModE);
                    wrap_d = 1'b1;
                end
`ifdef UPDOWN_PINGPONG_EN
                if (SATURATE == 0 && up_sum >= MaxE) begin
                    cnt_d  = MaxW;
                    dir_d  = 1'b1;
                    wrap_d = 1'b1;
                end
`endif
            end else begin
                if (!dn_ovf) begin
                    cnt_d = WIDTH'(cnt_e - StepE);
                end else if (SATURATE != 0) begin
                    cnt_d  = '0;
                    wrap_d = (cnt_q != '0);
                end else begin
                    cnt_d  = WIDTH'(cnt_e + ModE - StepE);
                    wrap_d = 1'b1;
                end
`ifdef UPDOWN_PINGPONG_EN
                if (SATURATE == 0 && cnt_e <= StepE) begin
                    cnt_d  = '0;
                    dir_d  = 1'b0;
                    wrap_d = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            swap_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            swap_q <= Swap;
            wrap_q <= wrap_d;
        end
    end

    assign UpCountS   = cnt_q;
    assign DownCountS = MaxW - cnt_q;
    assign Dir        = dir_q;
    assign Wrap       = wrap_q;
    assign AtLimit    = dir_q ? (cnt_q == '0) : (cnt_q == MaxW);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: vector table on a MAX_VAL=9 counter,
// plus hand sequences for step/saturate underflow and asynchronous reset.
module tb_updown_mod_counter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: MAX_VAL=9, STEP=1, wrap
    logic       a_en, a_sw, a_ld;
    logic [3:0] a_lv;
    logic [3:0] a_up, a_dn;
    logic       a_dir, a_atl, a_wr;

    // B/C: MAX_VAL=9, STEP=3, wrap (B) and saturate (C), shared stimulus
    logic       s_en, s_sw, s_ld;
    logic [3:0] s_lv;
    logic [3:0] b_up, b_dn, c_up, c_dn;
    logic       b_dir, b_atl, b_wr, c_dir, c_atl, c_wr;

    // D: default parameters (WIDTH=4, MAX_VAL=15)
    logic       d_en, d_sw, d_ld;
    logic [3:0] d_lv;
    logic [3:0] d_up, d_dn;
    logic       d_dir, d_atl, d_wr;

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(0)) u_a (
        .Clk(clk), .Reset(rst), .Enable(a_en), .Swap(a_sw), .Load(a_ld),
        .LoadVal(a_lv), .UpCountS(a_up), .DownCountS(a_dn), .Dir(a_dir),
        .AtLimit(a_atl), .Wrap(a_wr)
    );

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(0)) u_b (
        .Clk(clk), .Reset(rst), .Enable(s_en), .Swap(s_sw), .Load(s_ld),
        .LoadVal(s_lv), .UpCountS(b_up), .DownCountS(b_dn), .Dir(b_dir),
        .AtLimit(b_atl), .Wrap(b_wr)
    );

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(1)) u_c (
        .Clk(clk), .Reset(rst), .Enable(s_en), .Swap(s_sw), .Load(s_ld),
        .LoadVal(s_lv), .UpCountS(c_up), .DownCountS(c_dn), .Dir(c_dir),
        .AtLimit(c_atl), .Wrap(c_wr)
    );

    updown_mod_counter u_d (
        .Clk(clk), .Reset(rst), .Enable(d_en), .Swap(d_sw), .Load(d_ld),
        .LoadVal(d_lv), .UpCountS(d_up), .DownCountS(d_dn), .Dir(d_dir),
        .AtLimit(d_atl), .Wrap(d_wr)
    );

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       sw;
        logic [3:0] cnt;
        logic       dir;
        logic       wr;
        logic       atl;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [3:0] lv, input logic en,
                       input logic sw, input logic [3:0] cnt, input logic dir,
                       input logic wr, input logic atl);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = en; v.sw = sw;
        v.cnt = cnt; v.dir = dir; v.wr = wr; v.atl = atl;
        vecs.push_back(v);
    endtask

    task automatic chk_s(input string tag, input int bc, input int bw,
                         input int cc, input int cw, input int dir);
        check({tag, " B cnt"}, int'(b_up), bc);
        check({tag, " B down"}, int'(b_dn), 9 - bc);
        check({tag, " B wrap"}, int'(b_wr), bw);
        check({tag, " C cnt"}, int'(c_up), cc);
        check({tag, " C wrap"}, int'(c_wr), cw);
        check({tag, " B dir"}, int'(b_dir), dir);
        check({tag, " C dir"}, int'(c_dir), dir);
    endtask

    task automatic s_step(input logic ld, input logic [3:0] lv,
                          input logic en, input logic sw);
        @(negedge clk);
        s_ld = ld; s_lv = lv; s_en = en; s_sw = sw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        a_en = 0; a_sw = 0; a_ld = 0; a_lv = '0;
        s_en = 0; s_sw = 0; s_ld = 0; s_lv = '0;
        d_en = 0; d_sw = 0; d_ld = 0; d_lv = '0;

        // cycles 1-9: count up 1..9; 10: wrap to 0; 11-14: 1..4
        for (int i = 1; i <= 9; i++)
            add(0, 0, 1, 0, 4'(i), 0, 0, (i == 9));
        add(0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 2, 0, 0, 0);
        add(0, 0, 1, 0, 3, 0, 0, 0);
        add(0, 0, 1, 0, 4, 0, 0, 0);
        // swap pulse at 4: old dir gives 5, then 4, 3
        add(0, 0, 1, 1, 5, 1, 0, 0);
        add(0, 0, 1, 0, 4, 1, 0, 0);
        add(0, 0, 1, 0, 3, 1, 0, 0);
        // swap held 5 cycles, enable low: one toggle, count holds
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 1, 0, 4, 0, 0, 0);
        // load beats enable and clamps 12 -> 9
        add(1, 12, 1, 0, 9, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 1, 0);
        add(1, 7, 0, 0, 7, 0, 0, 0);
        add(0, 0, 0, 1, 7, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 1);
        // underflow down from 0 -> 9
        add(0, 0, 1, 0, 9, 1, 1, 0);
        add(0, 0, 1, 0, 8, 1, 0, 0);
        // swap edge alongside a load
        add(1, 3, 0, 1, 3, 0, 0, 0);
        add(0, 0, 0, 0, 3, 0, 0, 0);

        #1;
        check("reset A cnt", int'(a_up), 0);
        check("reset A down", int'(a_dn), 9);
        check("reset A dir", int'(a_dir), 0);
        check("reset A wrap", int'(a_wr), 0);
        check("reset A atlimit", int'(a_atl), 0);
        check("reset D down", int'(d_dn), 15);

        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            a_ld = vecs[i].ld; a_lv = vecs[i].lv;
            a_en = vecs[i].en; a_sw = vecs[i].sw;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d cnt", i), int'(a_up), int'(vecs[i].cnt));
            check($sformatf("vec%0d down", i), int'(a_dn), 9 - int'(vecs[i].cnt));
            check($sformatf("vec%0d dir", i), int'(a_dir), int'(vecs[i].dir));
            check($sformatf("vec%0d wrap", i), int'(a_wr), int'(vecs[i].wr));
            check($sformatf("vec%0d atlimit", i), int'(a_atl), int'(vecs[i].atl));
        end

        // STEP=3 underflow in wrap (B) and saturate (C) mode
        s_step(1, 1, 0, 1);
        chk_s("load1", 1, 0, 1, 0, 1);
        s_step(0, 0, 1, 0);
        chk_s("under", 8, 1, 0, 1, 1);
        check("C atlimit at 0", int'(c_atl), 1);
        s_step(0, 0, 1, 0);
        chk_s("after under", 5, 0, 0, 0, 1);
        s_step(0, 0, 1, 0);
        chk_s("hold 0", 2, 0, 0, 0, 1);
        // STEP=3 overflow upward
        s_step(1, 8, 0, 1);
        chk_s("load8", 8, 0, 8, 0, 0);
        s_step(0, 0, 1, 0);
        chk_s("over", 1, 1, 9, 1, 0);
        s_step(0, 0, 1, 0);
        chk_s("hold 9", 4, 0, 9, 0, 0);

        // default-width counter: count to 7 then reset mid-cycle
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            d_en = 1'b1;
        end
        @(posedge clk);
        #1;
        check("D pre-reset cnt", int'(d_up), 7);
        @(negedge clk);
        d_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("D async cnt", int'(d_up), 0);
        check("D async down", int'(d_dn), 15);
        check("D async dir", int'(d_dir), 0);
        check("D async wrap", int'(d_wr), 0);
        check("D async atlimit", int'(d_atl), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
